// File: rtl/input_conditioner.sv
// ---------------------------------------------------------------------------
// input_conditioner
//
// Purpose:
//   Multi-channel conditioner for push-buttons, mouse lines and other
//   asynchronous board inputs. Each channel runs through:
//     synchronizer -> hysteresis debouncer -> mode-selectable edge detector
//     -> retriggerable pulse stretcher -> sticky event flag
//   One instance serves every board input in the clk domain.
//
// Parameters:
//   CHANNELS     number of independent channels (>=1)
//   SYNC_STAGES  synchronizer flops per channel (>=1)
//   DEB_DEPTH    identical consecutive samples needed to flip the level (>=2)
//   STRETCH_LEN  cycles 'stretched' stays high per qualifying edge (>=1)
//
// Ports:
//   clk         system clock, all state updates on the rising edge
//   rst         synchronous reset, active low
//   in          raw asynchronous inputs, one bit per channel
//   mode        per-channel edge mode, bits [2i+1:2i] belong to channel i
//                 00 rising only, 01 falling only, 10 both, 11 disabled
//   flag_clr    per-channel write-1-to-clear for event_flag
//   level       debounced level
//   pulse       one-cycle strobe on each qualifying edge
//   stretched   pulse extended to STRETCH_LEN cycles (retriggerable)
//   event_flag  sticky "qualifying edge seen" flag
//   busy        OR of all stretched bits, cycle-aligned with stretched
//
// Every output is driven straight from a flop; there is no combinational
// path from any input to any output.
// ---------------------------------------------------------------------------
module input_conditioner #(
    parameter int CHANNELS    = 4,
    parameter int SYNC_STAGES = 2,
    parameter int DEB_DEPTH   = 4,
    parameter int STRETCH_LEN = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CHANNELS-1:0]   in,
    input  logic [2*CHANNELS-1:0] mode,
    input  logic [CHANNELS-1:0]   flag_clr,
    output logic [CHANNELS-1:0]   level,
    output logic [CHANNELS-1:0]   pulse,
    output logic [CHANNELS-1:0]   stretched,
    output logic [CHANNELS-1:0]   event_flag,
    output logic                  busy
);

    // Stretch counter width is derived from STRETCH_LEN and never overridden.
    localparam int CNT_W = $clog2(STRETCH_LEN + 1);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(STRETCH_LEN);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;

    // Per-channel edge qualification modes.
    typedef enum logic [1:0] {
        MODE_RISE = 2'b00,
        MODE_FALL = 2'b01,
        MODE_BOTH = 2'b10,
        MODE_OFF  = 2'b11
    } edge_mode_e;

    // -----------------------------------------------------------------------
    // State registers and their next-state values
    // -----------------------------------------------------------------------
    logic [CHANNELS-1:0][SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CHANNELS-1:0][DEB_DEPTH-1:0]   deb_q,  deb_d;
    logic [CHANNELS-1:0]                  level_q, level_d;
    logic [CHANNELS-1:0]                  pulse_q, pulse_d;
    logic [CHANNELS-1:0][CNT_W-1:0]       cnt_q,  cnt_d;
    logic [CHANNELS-1:0]                  flag_q, flag_d;
    logic                                 busy_q, busy_d;

    // -----------------------------------------------------------------------
    // Combinational helpers
    // -----------------------------------------------------------------------
    logic [CHANNELS-1:0] syncOut;
    logic [CHANNELS-1:0] levelRise;
    logic [CHANNELS-1:0] levelFall;
    logic [CHANNELS-1:0] qualify;
    logic [CHANNELS-1:0] stretchNext;

    // Synchronizer: bit 0 captures the raw input, the last bit is the
    // metastability-filtered sample handed on to the debouncer.
    always_comb begin
        sync_d  = sync_q;
        syncOut = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            sync_d[c][0] = in[c];
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_d[c][s] = sync_q[c][s-1];
            end
            syncOut[c] = sync_q[c][SYNC_STAGES-1];
        end
    end

    // Hysteresis debouncer: the level flips only on the edge where the
    // history window becomes uniformly ones or zeros. Looking at deb_d rather
    // than deb_q lets level change on that very edge instead of one later.
    always_comb begin
        deb_d   = deb_q;
        level_d = level_q;
        for (int c = 0; c < CHANNELS; c++) begin
            deb_d[c] = {deb_q[c][DEB_DEPTH-2:0], syncOut[c]};
            if (&deb_d[c]) begin
                level_d[c] = 1'b1;
            end else if (~|deb_d[c]) begin
                level_d[c] = 1'b0;
            end else begin
                level_d[c] = level_q[c];
            end
        end
    end

    // Edge detection and qualification. The mode is sampled on the edge where
    // level changes, so a mode change only matters for the next transition.
    always_comb begin
        levelRise = level_d & ~level_q;
        levelFall = ~level_d & level_q;
        qualify   = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            case (mode[2*c +: 2])
                MODE_RISE: qualify[c] = levelRise[c];
                MODE_FALL: qualify[c] = levelFall[c];
                MODE_BOTH: qualify[c] = levelRise[c] | levelFall[c];
                MODE_OFF:  qualify[c] = 1'b0;
                default:   qualify[c] = 1'b0;
            endcase
        end
    end

    // Pulse, stretcher and sticky flag. A qualifying edge reloads the counter
    // even mid-stretch, so back-to-back edges merge into one long stretch.
    // For the flag, a set on the same edge as a clear takes precedence.
    always_comb begin
        pulse_d     = qualify;
        cnt_d       = cnt_q;
        flag_d      = flag_q;
        stretchNext = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (qualify[c]) begin
                cnt_d[c] = CNT_LOAD;
            end else if (cnt_q[c] != CNT_ZERO) begin
                cnt_d[c] = cnt_q[c] - CNT_ONE;
            end else begin
                cnt_d[c] = CNT_ZERO;
            end
            stretchNext[c] = (cnt_d[c] != CNT_ZERO);

            if (qualify[c]) begin
                flag_d[c] = 1'b1;
            end else if (flag_clr[c]) begin
                flag_d[c] = 1'b0;
            end else begin
                flag_d[c] = flag_q[c];
            end
        end
        busy_d = |stretchNext;
    end

    // State register with synchronous active-low reset; reset overrides every
    // other update and aborts any debounce or stretch in progress.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_q  <= '0;
            deb_q   <= '0;
            level_q <= '0;
            pulse_q <= '0;
            cnt_q   <= '0;
            flag_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            deb_q   <= deb_d;
            level_q <= level_d;
            pulse_q <= pulse_d;
            cnt_q   <= cnt_d;
            flag_q  <= flag_d;
            busy_q  <= busy_d;
        end
    end

    // Output mapping; stretched is a pure decode of the counter register.
    always_comb begin
        level      = level_q;
        pulse      = pulse_q;
        event_flag = flag_q;
        busy       = busy_q;
        stretched  = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            stretched[c] = (cnt_q[c] != CNT_ZERO);
        end
    end

endmodule

// File: tb/tb_input_conditioner.sv
// ---------------------------------------------------------------------------
// tb_input_conditioner
//
// Scoreboard bench for input_conditioner at default parameters. Stimulus
// pushes expected per-channel output snapshots and pulse counts, keyed to an
// absolute cycle number, into a queue; an independent monitor on the falling
// clock edge pops entries whose cycle has arrived and compares them.
// Cycle numbering: t0 is captured at a falling edge, so rel=1 is the first
// rising edge that samples the newly applied inputs.
// ---------------------------------------------------------------------------
module tb_input_conditioner;

    localparam int CH = 4;

    typedef struct {
        int    cyc;
        int    kind;     // 0 = output snapshot, 1 = pulse count
        int    ch;
        logic  l;
        logic  p;
        logic  s;
        logic  f;
        logic  b;
        int    cnt;
        string tag;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic [CH-1:0]   inSig;
    logic [2*CH-1:0] modeSig;
    logic [CH-1:0]   flagClr;
    logic [CH-1:0]   level;
    logic [CH-1:0]   pulse;
    logic [CH-1:0]   stretched;
    logic [CH-1:0]   eventFlag;
    logic            busy;

    int   cyc = 0;
    int   t0  = 0;
    int   errors = 0;
    int   checks = 0;
    exp_t expQ[$];

    input_conditioner #(
        .CHANNELS   (CH),
        .SYNC_STAGES(2),
        .DEB_DEPTH  (4),
        .STRETCH_LEN(7)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in        (inSig),
        .mode      (modeSig),
        .flag_clr  (flagClr),
        .level     (level),
        .pulse     (pulse),
        .stretched (stretched),
        .event_flag(eventFlag),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // -----------------------------------------------------------------------
    // Monitor side
    // -----------------------------------------------------------------------
    int pulseCnt [CH] = '{default: 0};
    int pulseBase[CH] = '{default: 0};

    task automatic checkOutput(input string name, input int act, input int expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, expv);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        for (int i = expQ.size() - 1; i >= 0; i--) begin
            e = expQ[i];
            if (e.cyc < cyc) begin
                checkOutput({e.tag, ".missed"}, e.cyc, cyc);
                expQ.delete(i);
            end else if (e.cyc == cyc) begin
                if (e.kind == 0) begin
                    checkOutput($sformatf("%s.ch%0d.level", e.tag, e.ch),      int'(level[e.ch]),     int'(e.l));
                    checkOutput($sformatf("%s.ch%0d.pulse", e.tag, e.ch),      int'(pulse[e.ch]),     int'(e.p));
                    checkOutput($sformatf("%s.ch%0d.stretched", e.tag, e.ch),  int'(stretched[e.ch]), int'(e.s));
                    checkOutput($sformatf("%s.ch%0d.event_flag", e.tag, e.ch), int'(eventFlag[e.ch]), int'(e.f));
                    checkOutput($sformatf("%s.busy", e.tag),                   int'(busy),            int'(e.b));
                end else begin
                    checkOutput($sformatf("%s.ch%0d.pulse_count", e.tag, e.ch),
                                pulseCnt[e.ch] - pulseBase[e.ch], e.cnt);
                    pulseBase[e.ch] = pulseCnt[e.ch];
                end
                expQ.delete(i);
            end
        end
        for (int c = 0; c < CH; c++) begin
            if (pulse[c] === 1'b1) pulseCnt[c]++;
        end
    end

    // -----------------------------------------------------------------------
    // Stimulus side
    // -----------------------------------------------------------------------
    task automatic expectAt(input int rel, input int ch, input logic l, input logic p,
                            input logic s, input logic f, input logic b, input string tag);
        exp_t e;
        e.cyc = t0 + rel; e.kind = 0; e.ch = ch;
        e.l = l; e.p = p; e.s = s; e.f = f; e.b = b;
        e.cnt = 0; e.tag = tag;
        expQ.push_back(e);
    endtask

    task automatic expectCount(input int rel, input int ch, input int n, input string tag);
        exp_t e;
        e.cyc = t0 + rel; e.kind = 1; e.ch = ch;
        e.l = 1'b0; e.p = 1'b0; e.s = 1'b0; e.f = 1'b0; e.b = 1'b0;
        e.cnt = n; e.tag = tag;
        expQ.push_back(e);
    endtask

    task automatic startTest();
        @(negedge clk);
        t0 = cyc;
    endtask

    task automatic runTo(input int rel);
        while (cyc < t0 + rel) @(negedge clk);
    endtask

    task automatic applyStimulus(input int ch, input logic inVal);
        inSig[ch] = inVal;
    endtask

    // Per-mode expectations for the channel-2 sweep: pulse/stretch/busy at
    // the rise (rel 6) and fall (rel 26), the flag at the fall, total pulses.
    logic riseHit [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic fallHit [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic flagFall[4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    int   sweepCnt[4] = '{1, 1, 2, 0};

    initial begin
        rst     = 1'b0;
        inSig   = '0;
        modeSig = '0;
        flagClr = '0;

        // Reset state
        startTest();
        for (int c = 0; c < CH; c++) expectAt(2, c, 0, 0, 0, 0, 0, "reset");
        runTo(3);
        rst = 1'b1;

        // Test 1: channel 0 rises and stays high, mode 00
        startTest();
        applyStimulus(0, 1'b1);
        expectAt(5,  0, 0, 0, 0, 0, 0, "t1.pre");
        expectAt(6,  0, 1, 1, 1, 1, 1, "t1.rise");
        expectAt(7,  0, 1, 0, 1, 1, 1, "t1.after");
        expectAt(12, 0, 1, 0, 1, 1, 1, "t1.lastStretch");
        expectAt(13, 0, 1, 0, 0, 1, 0, "t1.stretchEnd");
        expectAt(14, 0, 1, 0, 0, 1, 0, "t1.flagHeld");
        expectAt(15, 0, 1, 0, 0, 0, 0, "t1.flagClr");
        expectAt(21, 0, 1, 0, 0, 0, 0, "t1.preFall");
        expectAt(22, 0, 0, 0, 0, 0, 0, "t1.fallNoPulse");
        expectCount(24, 0, 1, "t1");
        runTo(14); flagClr[0] = 1'b1;
        runTo(15); flagClr[0] = 1'b0;
        runTo(16); applyStimulus(0, 1'b0);
        runTo(24);

        // Test 2a: three-cycle glitch on channel 1 is rejected
        startTest();
        applyStimulus(1, 1'b1);
        expectAt(6, 1, 0, 0, 0, 0, 0, "t2a");
        expectAt(7, 1, 0, 0, 0, 0, 0, "t2a");
        expectAt(8, 1, 0, 0, 0, 0, 0, "t2a");
        expectCount(12, 1, 0, "t2a");
        runTo(3); applyStimulus(1, 1'b0);
        runTo(14);

        // Test 2b: four-cycle glitch just passes, giving one pulse
        startTest();
        applyStimulus(1, 1'b1);
        expectAt(5,  1, 0, 0, 0, 0, 0, "t2b.pre");
        expectAt(6,  1, 1, 1, 1, 1, 1, "t2b.rise");
        expectAt(9,  1, 1, 0, 1, 1, 1, "t2b.hold");
        expectAt(10, 1, 0, 0, 1, 1, 1, "t2b.fall");
        expectAt(13, 1, 0, 0, 0, 1, 0, "t2b.stretchEnd");
        expectAt(17, 1, 0, 0, 0, 0, 0, "t2b.flagClr");
        expectCount(16, 1, 1, "t2b");
        runTo(4);  applyStimulus(1, 1'b0);
        runTo(16); flagClr[1] = 1'b1;
        runTo(17); flagClr[1] = 1'b0;
        runTo(18);

        // Test 3: mode sweep on channel 2, 20 cycles high then 20 low
        for (int m = 0; m < 4; m++) begin
            startTest();
            modeSig[5:4] = 2'(m);
            applyStimulus(2, 1'b1);
            expectAt(5,  2, 0, 0, 0, 0, 0, $sformatf("t3.m%0d.pre", m));
            expectAt(6,  2, 1, riseHit[m], riseHit[m], riseHit[m], riseHit[m], $sformatf("t3.m%0d.rise", m));
            expectAt(26, 2, 0, fallHit[m], fallHit[m], flagFall[m], fallHit[m], $sformatf("t3.m%0d.fall", m));
            expectCount(38, 2, sweepCnt[m], $sformatf("t3.m%0d", m));
            runTo(20); applyStimulus(2, 1'b0);
            runTo(38); flagClr[2] = 1'b1;
            runTo(39); flagClr[2] = 1'b0;
            runTo(40);
        end

        // Test 4: retrigger on channel 2 with edges four cycles apart, the
        // closest the debouncer allows; the stretch runs 4+7 cycles unbroken
        startTest();
        modeSig[5:4] = 2'b10;
        applyStimulus(2, 1'b1);
        expectAt(6,  2, 1, 1, 1, 1, 1, "t4.first");
        expectAt(9,  2, 1, 0, 1, 1, 1, "t4.mid");
        expectAt(10, 2, 0, 1, 1, 1, 1, "t4.second");
        expectAt(13, 2, 0, 0, 1, 1, 1, "t4.reloaded");
        expectAt(16, 2, 0, 0, 1, 1, 1, "t4.lastStretch");
        expectAt(17, 2, 0, 0, 0, 1, 0, "t4.stretchEnd");
        expectCount(20, 2, 2, "t4");
        runTo(4);  applyStimulus(2, 1'b0);
        runTo(22); flagClr[2] = 1'b1;
        runTo(23); flagClr[2] = 1'b0;
        runTo(24);

        // Test 5: flag clear racing a set on channel 3, then a plain clear
        startTest();
        modeSig[7:6] = 2'b00;
        applyStimulus(3, 1'b1);
        expectAt(5,  3, 0, 0, 0, 0, 0, "t5.pre");
        expectAt(6,  3, 1, 1, 1, 1, 1, "t5.setWins");
        expectAt(7,  3, 1, 0, 1, 1, 1, "t5.held");
        expectAt(8,  3, 1, 0, 1, 0, 1, "t5.cleared");
        expectAt(16, 3, 0, 0, 0, 0, 0, "t5.fall");
        expectCount(19, 3, 1, "t5");
        runTo(5);  flagClr[3] = 1'b1;
        runTo(6);  flagClr[3] = 1'b0;
        runTo(7);  flagClr[3] = 1'b1;
        runTo(8);  flagClr[3] = 1'b0;
        runTo(10); applyStimulus(3, 1'b0);
        runTo(20);

        // Test 6: reset for one edge mid-stretch, input kept high
        startTest();
        applyStimulus(0, 1'b1);
        expectAt(6,  0, 1, 1, 1, 1, 1, "t6.rise");
        expectAt(8,  0, 1, 0, 1, 1, 1, "t6.stretching");
        for (int c = 0; c < CH; c++) expectAt(9, c, 0, 0, 0, 0, 0, "t6.reset");
        expectAt(14, 0, 0, 0, 0, 0, 0, "t6.preRerise");
        expectAt(15, 0, 1, 1, 1, 1, 1, "t6.rerise");
        expectAt(16, 0, 1, 0, 1, 1, 1, "t6.after");
        expectAt(22, 0, 1, 0, 0, 1, 0, "t6.stretchEnd");
        expectCount(24, 0, 2, "t6");
        runTo(8);  rst = 1'b0;
        runTo(9);  rst = 1'b1;
        runTo(26);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
